// File: rtl/lcd_bus_arbiter.sv
// lcd_bus_arbiter: fixed-priority arbiter and write sequencer for a shared
// HD44780-style character-LCD write bus (init sequencer vs. display engine).
module lcd_bus_arbiter #(
    parameter int T_SETUP     = 2,
    parameter int T_PW        = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 80000
) (
    input  logic       CLK_50M,
    input  logic       rst,
    input  logic       req0,
    input  logic       rs0,
    input  logic [7:0] data0,
    output logic       ack0,
    input  logic       req1,
    input  logic       rs1,
    input  logic [7:0] data1,
    output logic       ack1,
    input  logic       init_done,
    output logic       LCD_RS,
    output logic       LCD_RW,
    output logic       LCD_EN,
    output logic [7:0] LCD_DATA,
    output logic       busy,
    output logic       grant
);

    localparam int MAX_A = (T_SETUP > T_PW) ? T_SETUP : T_PW;
    localparam int MAX_B = (T_HOLD > T_EXEC) ? T_HOLD : T_EXEC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_T = (MAX_C > T_EXEC_LONG) ? MAX_C : T_EXEC_LONG;
    localparam int CW    = (MAX_T > 1) ? $clog2(MAX_T) : 1;

    // Counter is loaded with duration-1 and the state exits on zero.
    localparam logic [CW-1:0] LD_SETUP = CW'(T_SETUP - 1);
    localparam logic [CW-1:0] LD_PW    = CW'(T_PW - 1);
    localparam logic [CW-1:0] LD_HOLD  = CW'(T_HOLD - 1);
    localparam logic [CW-1:0] LD_EXEC  = CW'(T_EXEC - 1);
    localparam logic [CW-1:0] LD_LONG  = CW'(T_EXEC_LONG - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_EN_HI,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rs_q, rs_d;
    logic [7:0]      data_q, data_d;
    logic            en_q, en_d;
    logic            ack0_q, ack0_d;
    logic            ack1_q, ack1_d;
    logic            grant_q, grant_d;
    logic            cnt_zero;
    logic            cmd_long;
    logic            blank;

    assign cnt_zero = (cnt_q == '0);
    assign blank    = ack0_q | ack1_q;

    // Clear display and return home need the long execution time.
    assign cmd_long = !rs_q &&
                      ((data_q == 8'h01) ||
                       (data_q == 8'h02) ||
                       (data_q == 8'h03));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rs_d    = rs_q;
        data_d  = data_q;
        grant_d = grant_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (!blank) begin
                    if (req0) begin
                        grant_d = 1'b0;
                        rs_d    = rs0;
                        data_d  = data0;
                        cnt_d   = LD_SETUP;
                        state_d = S_SETUP;
                    end else if (req1 && init_done) begin
                        grant_d = 1'b1;
                        rs_d    = rs1;
                        data_d  = data1;
                        cnt_d   = LD_SETUP;
                        state_d = S_SETUP;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_zero) begin
                    cnt_d   = LD_PW;
                    state_d = S_EN_HI;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_EN_HI: begin
                if (cnt_zero) begin
                    cnt_d   = LD_HOLD;
                    state_d = S_HOLD;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_HOLD: begin
                if (cnt_zero) begin
                    cnt_d   = cmd_long ? LD_LONG : LD_EXEC;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_WAIT: begin
                if (cnt_zero) begin
                    ack0_d  = !grant_q;
                    ack1_d  = grant_q;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // EN is a flop output so the strobe is free of decode glitches.
        en_d = (state_d == S_EN_HI);
    end

    always_ff @(posedge CLK_50M) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            en_q    <= 1'b0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            grant_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            en_q    <= en_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            grant_q <= grant_d;
        end
    end

    assign LCD_RS   = rs_q;
    assign LCD_RW   = 1'b0;
    assign LCD_EN   = en_q;
    assign LCD_DATA = data_q;
    assign ack0     = ack0_q;
    assign ack1     = ack1_q;
    assign busy     = (state_q != S_IDLE);
    assign grant    = grant_q;

endmodule
